// File: rtl/uart_tx_engine.sv
// uart_tx_engine
//   UART transmit engine fed by a show-ahead synchronous FIFO. Pops one byte
//   when idle and enabled, then sends it LSB-first as start/data/[parity]/stop
//   on txd. Each bit lasts div_l+1 clk cycles.
//
//   Optional feature: define UART_TX_PARITY_EN to build the parity bit
//   (odd/even chosen by parity_odd). Without it, frames go DATA -> STOP.
//
// Ports
//   clk, rstn      clock, asynchronous active-low reset
//   tx_en          allows a new byte to be popped (never aborts a frame)
//   baud_div       bit period minus one, in clk cycles
//   stop2          0 = one stop bit, 1 = two stop bits
//   parity_odd     0 = even, 1 = odd parity (parity build only)
//   fifo_rd_empty  FIFO empty flag
//   fifo_q         FIFO head data (show-ahead)
//   fifo_rd_req    combinational pop strobe, one cycle per byte
//   txd            registered serial output, idle high
//   busy           high from the cycle after a pop until frame end
//   done           one-cycle pulse on the last clk of the final stop bit
//
// state  | meaning
// IDLE   | line high, pop a byte when enabled and FIFO not empty
// START  | start bit (txd=0)
// DATA   | data bits, LSB first
// PARITY | parity bit (UART_TX_PARITY_EN only)
// STOP   | one or two stop bits (txd=1), done on the last clk

module uart_tx_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  tx_en,
  input  logic [DIV_WIDTH-1:0]  baud_div,
  input  logic                  stop2,
  input  logic                  parity_odd,
  input  logic                  fifo_rd_empty,
  input  logic [DATA_WIDTH-1:0] fifo_q,
  output logic                  fifo_rd_req,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_l_q, div_l_d;
  logic                  stop2_l_q, stop2_l_d;
  logic [DIV_WIDTH-1:0]  baud_cnt_q, baud_cnt_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  txd_q, txd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pop;
  logic                  bit_end;

`ifdef UART_TX_PARITY_EN
  // Parity bit is resolved at pop time from the byte and the latched sense.
  logic                  par_l_q, par_l_d;
`else
  logic                  unused_parity_odd;
  assign unused_parity_odd = parity_odd;
`endif

  // rstn gating keeps the strobe low while the engine is held in reset.
  assign pop         = (state_q == IDLE) & tx_en & ~fifo_rd_empty & rstn;
  assign fifo_rd_req = pop;
  assign bit_end     = (baud_cnt_q == div_l_q);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_l_d    = div_l_q;
    stop2_l_d  = stop2_l_q;
    bit_cnt_d  = bit_cnt_q;
    baud_cnt_d = ((state_q == IDLE) || bit_end) ? '0 : baud_cnt_q + DIV_WIDTH'(1);
`ifdef UART_TX_PARITY_EN
    par_l_d    = par_l_q;
`endif

    case (state_q)
      IDLE: begin
        if (pop) begin
          shift_d   = fifo_q;
          div_l_d   = baud_div;
          stop2_l_d = stop2;
          bit_cnt_d = '0;
          state_d   = START;
`ifdef UART_TX_PARITY_EN
          par_l_d   = (^fifo_q) ^ parity_odd;
`endif
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == CNT_W'(stop2_l_q)) state_d = IDLE;
          else                                bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from next-state values so txd/busy/done line up
    // with the bit actually on the wire.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = par_l_d;
`endif
      default: txd_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (baud_cnt_d == div_l_d) &&
             (bit_cnt_d == CNT_W'(stop2_l_d));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      div_l_q    <= '0;
      stop2_l_q  <= 1'b0;
      baud_cnt_q <= '0;
      bit_cnt_q  <= '0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_l_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_l_q    <= div_l_d;
      stop2_l_q  <= stop2_l_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
      par_l_q    <= par_l_d;
`endif
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine
//   Directed bench for uart_tx_engine with a small show-ahead FIFO model.
//   Expected frames are built from the byte, divisor, stop and parity settings.
//   Parity expectations follow UART_TX_PARITY_EN when it is defined.

module tb_uart_tx_engine;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        tx_en;
  logic [15:0] baud_div;
  logic        stop2;
  logic        parity_odd;
  logic        fifo_rd_empty;
  logic [7:0]  fifo_q;
  logic        fifo_rd_req;
  logic        txd;
  logic        busy;
  logic        done;

  int nvec = 0;
  int nerr = 0;

  logic [7:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int pop_cnt = 0;
  int bad_pop = 0;
  int both_cnt = 0;
  int busy_pop = 0;

  uart_tx_engine #(.DATA_WIDTH(8), .DIV_WIDTH(16)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .tx_en         (tx_en),
    .baud_div      (baud_div),
    .stop2         (stop2),
    .parity_odd    (parity_odd),
    .fifo_rd_empty (fifo_rd_empty),
    .fifo_q        (fifo_q),
    .fifo_rd_req   (fifo_rd_req),
    .txd           (txd),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  assign fifo_rd_empty = (rd_ptr == wr_ptr);
  assign fifo_q        = mem[rd_ptr % 16];

  always @(posedge clk) begin
    if (fifo_rd_req && (rd_ptr != wr_ptr)) rd_ptr <= rd_ptr + 1;
    if (fifo_rd_req) pop_cnt <= pop_cnt + 1;
    if (fifo_rd_req && (rd_ptr == wr_ptr)) bad_pop <= bad_pop + 1;
    if (fifo_rd_req && done) both_cnt <= both_cnt + 1;
    if (fifo_rd_req && busy) busy_pop <= busy_pop + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 16] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_pop(input int maxc, output int waited);
    #1;
    waited = 0;
    while (fifo_rd_req !== 1'b1 && waited < maxc) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("pop_seen", {31'd0, fifo_rd_req}, 32'd1);
  endtask

  // Called in the pop cycle; walks the whole frame then the following cycle.
  task automatic check_frame(input logic [7:0] data, input int div, input bit s2,
                             input bit podd, input string tag, input int chg_at);
    logic [11:0] bits;
    logic        e;
    int nb, len, bad_txd, bad_busy, bad_done;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
    if (P == 1) bits[9] = (^data) ^ podd;
    nb = 1 + 8 + P + (s2 ? 2 : 1);
    len = nb * (div + 1);
    bad_txd = 0; bad_busy = 0; bad_done = 0;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      if (k == chg_at) begin
        baud_div = 16'd9;
        tx_en = 1'b0;
      end
      e = bits[k / (div + 1)];
      if (txd !== e) bad_txd++;
      if (busy !== 1'b1) bad_busy++;
      if (done !== (k == len - 1)) bad_done++;
    end
    chk({tag, "_txd_bad"}, bad_txd, 0);
    chk({tag, "_busy_bad"}, bad_busy, 0);
    chk({tag, "_done_bad"}, bad_done, 0);
    @(negedge clk);
    chk({tag, "_post_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_post_txd"}, {31'd0, txd}, 32'd1);
    chk({tag, "_post_done"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, p0, cnt_req, cnt_txd, cnt_busy;
    rstn = 1'b0; tx_en = 1'b0; baud_div = 16'd0; stop2 = 1'b0; parity_odd = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_req", {31'd0, fifo_rd_req}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // single byte 0x55, 4 clk per bit, one stop bit
    baud_div = 16'd3; stop2 = 1'b0; tx_en = 1'b1;
    p0 = pop_cnt;
    push(8'h55);
    wait_pop(10, w);
    check_frame(8'h55, 3, 1'b0, 1'b0, "single", -1);
    chk("single_pops", pop_cnt - p0, 1);

    // byte 0x07, 1 clk per bit, odd then even parity
    baud_div = 16'd0; parity_odd = 1'b1;
    push(8'h07);
    wait_pop(10, w);
    check_frame(8'h07, 0, 1'b0, 1'b1, "par_odd", -1);
    parity_odd = 1'b0;
    push(8'h07);
    wait_pop(10, w);
    check_frame(8'h07, 0, 1'b0, 1'b0, "par_even", -1);

    // back-to-back: three preloaded bytes, 2 clk per bit, two stop bits
    tx_en = 1'b0;
    @(negedge clk);
    push(8'hA0); push(8'h0F); push(8'hFF);
    baud_div = 16'd1; stop2 = 1'b1;
    p0 = pop_cnt;
    tx_en = 1'b1;
    wait_pop(10, w);
    check_frame(8'hA0, 1, 1'b1, 1'b0, "b2b0", -1);
    wait_pop(5, w);
    chk("b2b_gap1", w, 0);
    check_frame(8'h0F, 1, 1'b1, 1'b0, "b2b1", -1);
    wait_pop(5, w);
    chk("b2b_gap2", w, 0);
    check_frame(8'hFF, 1, 1'b1, 1'b0, "b2b2", -1);
    chk("b2b_pops", pop_cnt - p0, 3);
    chk("b2b_empty", {31'd0, fifo_rd_empty}, 32'd1);
    chk("b2b_txd", {31'd0, txd}, 32'd1);

    // mid-frame divisor change and tx_en drop: frame keeps 3 clk/bit
    tx_en = 1'b0;
    @(negedge clk);
    push(8'h3C); push(8'h99);
    baud_div = 16'd2; stop2 = 1'b0;
    p0 = pop_cnt;
    tx_en = 1'b1;
    wait_pop(10, w);
    check_frame(8'h3C, 2, 1'b0, 1'b0, "mid", 9);
    cnt_req = 0; cnt_txd = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (fifo_rd_req !== 1'b0) cnt_req++;
      if (txd !== 1'b1) cnt_txd++;
    end
    chk("mid_no_req", cnt_req, 0);
    chk("mid_idle_txd", cnt_txd, 0);
    chk("mid_pops", pop_cnt - p0, 1);
    chk("mid_fifo_held", {31'd0, fifo_rd_empty}, 32'd0);
    baud_div = 16'd1;
    tx_en = 1'b1;
    wait_pop(5, w);
    check_frame(8'h99, 1, 1'b0, 1'b0, "flush", -1);

    // async reset during data bit 4 (byte 0x4A has bit4 = 0)
    tx_en = 1'b0;
    @(negedge clk);
    push(8'h4A); push(8'hC3);
    baud_div = 16'd1; stop2 = 1'b0;
    p0 = pop_cnt;
    tx_en = 1'b1;
    wait_pop(10, w);
    repeat (11) @(negedge clk);
    chk("rstmid_pre_txd", {31'd0, txd}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("rstmid_txd", {31'd0, txd}, 32'd1);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_req", {31'd0, fifo_rd_req}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rstmid_pops", pop_cnt - p0, 1);
    rstn = 1'b1;
    wait_pop(3, w);
    chk("rstmid_first_idle_pop", w, 0);
    check_frame(8'hC3, 1, 1'b0, 1'b0, "rst_after", -1);
    chk("rst_after_pops", pop_cnt - p0, 2);
    chk("rst_after_empty", {31'd0, fifo_rd_empty}, 32'd1);

    // empty FIFO with tx_en high for 100 clk
    tx_en = 1'b1;
    cnt_req = 0; cnt_txd = 0; cnt_busy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (fifo_rd_req !== 1'b0) cnt_req++;
      if (txd !== 1'b1) cnt_txd++;
      if (busy !== 1'b0) cnt_busy++;
    end
    chk("empty_req", cnt_req, 0);
    chk("empty_txd", cnt_txd, 0);
    chk("empty_busy", cnt_busy, 0);

    chk("mon_pop_while_empty", bad_pop, 0);
    chk("mon_pop_with_done", both_cnt, 0);
    chk("mon_pop_while_busy", busy_pop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
